regfile_scoreboard: RTL and testbench

- Parametrised integer register file for the RISC-V core, and the successor to the single per-register enable flops.
- Provides N combinational read ports, one synchronous write port, hardwired x0 and a stack-pointer register with a nonzero reset value.
- Holds a per-register busy scoreboard so decode can detect RAW hazards against in-flight writebacks.
- Sits between decode (read/issue) and writeback (write/retire).

---
 rtl/regfile_scoreboard.sv | 106 ++++++++++
 tb/tb_regfile_scoreboard.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Integer register file with a per-register busy scoreboard.
// Decode reads operands and issues destinations. Writeback retires values.
//   - x0 is hardwired to zero and is never marked busy.
//   - reg[sp_index] resets to 2**addr_width_DMEM, truncated to bits.
//   - Reads are combinational. The write port is synchronous.
//   - hazard flags a RAW dependency on any operand that is actually used.
//
// Compile-time option: REGFILE_FWD_EN
//   When defined, a same-cycle writeback is forwarded to the read ports.
//   It also masks rd_busy for that register.
//
// Ports:
//   clk            rising-edge clock
//   async_reset_n  asynchronous active-low reset
//   rd_addr        packed read addresses; port p at slice p
//   rd_data        packed read data; port p at slice p
//   rd_busy        per-port pending-write flag
//   hazard         OR of rd_busy over ports with rd_used set
//   rd_used        per-port operand-consumed flag
//   issue_en       issue of an instruction that writes issue_addr
//   issue_addr     destination of the issued instruction
//   wr_en          writeback valid
//   wr_addr        writeback destination
//   wr_data        writeback value
module regfile_scoreboard #(
   parameter int bits            = 32,
   parameter int no_of_registers = 32,
   parameter int read_ports      = 2,
   parameter int sp_index        = 2,
   parameter int addr_width_DMEM = 10
) (
   input  logic                                      clk,
   input  logic                                      async_reset_n,
   input  logic [read_ports*$clog2(no_of_registers)-1:0] rd_addr,
   output logic [read_ports*bits-1:0]                rd_data,
   output logic [read_ports-1:0]                     rd_busy,
   output logic                                      hazard,
   input  logic [read_ports-1:0]                     rd_used,
   input  logic                                      issue_en,
   input  logic [$clog2(no_of_registers)-1:0]        issue_addr,
   input  logic                                      wr_en,
   input  logic [$clog2(no_of_registers)-1:0]        wr_addr,
   input  logic [bits-1:0]                           wr_data
);

   localparam int aw = $clog2(no_of_registers);
   localparam logic [bits-1:0] sp_reset_val = {{(bits-1){1'b0}}, 1'b1} << addr_width_DMEM;

   logic [bits-1:0]            regs [no_of_registers];
   logic [no_of_registers-1:0] busy;

   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         for (int r = 0; r < no_of_registers; r++) begin
            regs[r] <= (r == sp_index) ? sp_reset_val : '0;
         end
      end else if (wr_en && (wr_addr != '0)) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Set has priority over clear: a new producer supersedes a retiring one.
   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         busy <= '0;
      end else begin
         busy[0] <= 1'b0;
         for (int r = 1; r < no_of_registers; r++) begin
            if (issue_en && (issue_addr == aw'(r))) begin
               busy[r] <= 1'b1;
            end else if (wr_en && (wr_addr == aw'(r))) begin
               busy[r] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      logic [aw-1:0] a;
      logic          fwd_hit;
      rd_data = '0;
      rd_busy = '0;
      a       = '0;
      fwd_hit = 1'b0;
      for (int p = 0; p < read_ports; p++) begin
         a = rd_addr[p*aw +: aw];
`ifdef REGFILE_FWD_EN
         fwd_hit = wr_en && (wr_addr == a) && (a != '0);
`else
         fwd_hit = 1'b0;
`endif
         if (a == '0) begin
            rd_data[p*bits +: bits] = '0;
         end else if (fwd_hit) begin
            rd_data[p*bits +: bits] = wr_data;
         end else begin
            rd_data[p*bits +: bits] = regs[a];
         end
         rd_busy[p] = busy[a] && !fwd_hit;
      end
   end

   assign hazard = |(rd_busy & rd_used);

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

   logic        clk;
   logic        async_reset_n;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        hazard;
   logic [1:0]  rd_used;
   logic        issue_en;
   logic [4:0]  issue_addr;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      string       tag;
      logic [31:0] d1;
      logic [31:0] d0;
      logic [1:0]  busy;
      logic        haz;
   } exp_t;

   exp_t sb_q[$];

   regfile_scoreboard dut (
      .clk(clk), .async_reset_n(async_reset_n),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .hazard(hazard),
      .rd_used(rd_used), .issue_en(issue_en), .issue_addr(issue_addr),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive the read ports and queue the expected outputs for this cycle.
   task automatic rd(input string tag, input logic [4:0] a1, input logic [4:0] a0,
                     input logic [1:0] used, input logic [31:0] d1, input logic [31:0] d0,
                     input logic [1:0] busy, input logic haz);
      exp_t e;
      rd_addr = {a1, a0};
      rd_used = used;
      e.tag = tag; e.d1 = d1; e.d0 = d0; e.busy = busy; e.haz = haz;
      sb_q.push_back(e);
   endtask

   task automatic compare_out();
      exp_t e;
      #2;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({e.tag, ".d0"},   64'(rd_data[31:0]),  64'(e.d0));
         chk({e.tag, ".d1"},   64'(rd_data[63:32]), 64'(e.d1));
         chk({e.tag, ".busy"}, 64'(rd_busy),        64'(e.busy));
         chk({e.tag, ".haz"},  64'(hazard),         64'(e.haz));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_en = 1'b0; issue_addr = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
   endtask

   initial begin
      async_reset_n = 1'b0;
      rd_addr = '0; rd_used = '0;
      idle();
      step();
      rd("reset", 5'd2, 5'd0, 2'b11, 32'h400, 32'h0, 2'b00, 1'b0);
      compare_out();

      // A write attempted while reset is held has no effect.
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1111_1111;
      issue_en = 1'b1; issue_addr = 5'd5;
      step();
      idle();
      rd("reset_hold", 5'd5, 5'd5, 2'b11, 32'h0, 32'h0, 2'b00, 1'b0);
      compare_out();
      async_reset_n = 1'b1;
      step();

      // Write x5, then attempt a write to x0.
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
      step();
      wr_addr = 5'd0; wr_data = 32'h1234;
      step();
      idle();
      rd("x5_x0", 5'd5, 5'd0, 2'b11, 32'hDEADBEEF, 32'h0, 2'b00, 1'b0);
      compare_out();
      rd("same_addr", 5'd5, 5'd5, 2'b11, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1'b0);
      compare_out();

      // Same-cycle write and read of x7.
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
`ifdef REGFILE_FWD_EN
      rd("wr7_same", 5'd0, 5'd7, 2'b00, 32'h0, 32'hA5A5A5A5, 2'b00, 1'b0);
`else
      rd("wr7_same", 5'd0, 5'd7, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
`endif
      compare_out();
      step();
      idle();
      rd("wr7_next", 5'd0, 5'd7, 2'b00, 32'h0, 32'hA5A5A5A5, 2'b00, 1'b0);
      compare_out();

      // An issue to x0 never sets busy.
      issue_en = 1'b1; issue_addr = 5'd0;
      step();
      idle();
      rd("x0_issue", 5'd0, 5'd0, 2'b11, 32'h0, 32'h0, 2'b00, 1'b0);
      compare_out();

      // Issue x9, then retire it.
      issue_en = 1'b1; issue_addr = 5'd9;
      step();
      idle();
      rd("x9_busy", 5'd5, 5'd9, 2'b01, 32'hDEADBEEF, 32'h0, 2'b01, 1'b1);
      compare_out();
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
`ifdef REGFILE_FWD_EN
      rd("x9_retire", 5'd5, 5'd9, 2'b01, 32'hDEADBEEF, 32'h99, 2'b00, 1'b0);
`else
      rd("x9_retire", 5'd5, 5'd9, 2'b01, 32'hDEADBEEF, 32'h0, 2'b01, 1'b1);
`endif
      compare_out();
      step();
      idle();
      rd("x9_clear", 5'd5, 5'd9, 2'b01, 32'hDEADBEEF, 32'h99, 2'b00, 1'b0);
      compare_out();

      // An issue and a retire of x4 in the same cycle leave x4 busy.
      issue_en = 1'b1; issue_addr = 5'd4;
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
      step();
      idle();
      rd("x4_unused", 5'd0, 5'd4, 2'b00, 32'h0, 32'h44, 2'b01, 1'b0);
      compare_out();
      rd("x4_used", 5'd0, 5'd4, 2'b01, 32'h0, 32'h44, 2'b01, 1'b1);
      compare_out();
      rd("x4_port1", 5'd4, 5'd0, 2'b10, 32'h44, 32'h0, 2'b10, 1'b1);
      compare_out();
      // WAW: a second issue keeps x4 busy, and the first retire clears it.
      issue_en = 1'b1; issue_addr = 5'd4;
      step();
      idle();
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h45;
      step();
      idle();
      rd("x4_waw_clr", 5'd0, 5'd4, 2'b01, 32'h0, 32'h45, 2'b00, 1'b0);
      compare_out();

      // Reset asserted mid-cycle with x3 busy and holding 0x55.
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
      step();
      idle();
      wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h77;
      issue_en = 1'b1; issue_addr = 5'd3;
      step();
      idle();
      rd("x3_pre", 5'd2, 5'd3, 2'b11, 32'h77, 32'h55, 2'b01, 1'b1);
      compare_out();
      async_reset_n = 1'b0;
      rd("x3_async", 5'd2, 5'd3, 2'b11, 32'h400, 32'h0, 2'b00, 1'b0);
      compare_out();
      rd("x5_async", 5'd5, 5'd9, 2'b11, 32'h0, 32'h0, 2'b00, 1'b0);
      compare_out();
      step();
      async_reset_n = 1'b1;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
